// File: rtl/fft_mag_arbiter_if.sv
// Bus bundle for fft_mag_arbiter: two FFT bin streams, the magnitude-unit link
// and the tagged result stream. slave = arbiter side, master = surrounding logic.
interface fft_mag_arbiter_if #(
  parameter int W     = 16,
  parameter int NBINS = 256
) ();
  localparam int LB = $clog2(NBINS);

  logic           req0_valid, req0_ready, req0_last;
  logic [2*W-1:0] req0_re, req0_im;
  logic           req1_valid, req1_ready, req1_last;
  logic [2*W-1:0] req1_re, req1_im;

  logic           mp_valid;
  logic [2*W-1:0] mp_re, mp_im;
  logic           mp_mag_valid;
  logic [4*W-1:0] mp_mag_sq;

  logic           out_valid;
  logic [4*W-1:0] out_mag;
  logic           out_chan;
  logic [LB-1:0]  out_bin;
  logic           out_last;
  logic           frame_err;
  logic           tag_err;

  modport slave (
    input  req0_valid, req0_re, req0_im, req0_last,
    input  req1_valid, req1_re, req1_im, req1_last,
    input  mp_mag_valid, mp_mag_sq,
    output req0_ready, req1_ready,
    output mp_valid, mp_re, mp_im,
    output out_valid, out_mag, out_chan, out_bin, out_last, frame_err, tag_err
  );

  modport master (
    output req0_valid, req0_re, req0_im, req0_last,
    output req1_valid, req1_re, req1_im, req1_last,
    output mp_mag_valid, mp_mag_sq,
    input  req0_ready, req1_ready,
    input  mp_valid, mp_re, mp_im,
    input  out_valid, out_mag, out_chan, out_bin, out_last, frame_err, tag_err
  );
endinterface

// File: rtl/fft_mag_arbiter.sv
// Frame-level round-robin sharing of one |Re|^2+|Im|^2 unit between two FFT streams,
// with result tagging and frame-length checking. Optional stall abort: FFT_ARB_TIMEOUT_EN.
module fft_mag_arbiter #(
  parameter int W         = 16,
  parameter int NBINS     = 256,
  parameter int TAG_DEPTH = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic             clk,
  input  logic             reset_n,
  fft_mag_arbiter_if.slave bus
);
  localparam int LB  = $clog2(NBINS);
  localparam int PW  = $clog2(TAG_DEPTH);
  localparam int CW  = $clog2(TAG_DEPTH + 1);
  localparam int TGW = LB + 2;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state, state_nxt;
  logic           gnt, gnt_nxt;  // granted channel, doubling as the round-robin pointer
  logic [LB-1:0]  bin;
  logic [TGW-1:0] tag_mem [TAG_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;

  logic           g_valid, g_last, bin_max, fifo_full;
  logic           accept, frame_end, pop, abort;
  logic [2*W-1:0] g_re, g_im;

  assign g_valid = gnt ? bus.req1_valid : bus.req0_valid;
  assign g_last  = gnt ? bus.req1_last  : bus.req0_last;
  assign g_re    = gnt ? bus.req1_re    : bus.req0_re;
  assign g_im    = gnt ? bus.req1_im    : bus.req0_im;
  assign bin_max = (bin == LB'(NBINS - 1));

  // A pop in the same cycle frees a slot; without this a 4-deep FIFO behind the
  // 3-cycle unit would stall every fifth bin.
  assign fifo_full = (count == CW'(TAG_DEPTH)) && !bus.mp_mag_valid;
  assign pop       = bus.mp_mag_valid && (count != '0);

  always_comb begin
    state_nxt      = state;
    gnt_nxt        = gnt;
    accept         = 1'b0;
    frame_end      = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          gnt_nxt   = (bus.req0_valid && bus.req1_valid) ? ~gnt : bus.req1_valid;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        bus.req0_ready = !gnt && !fifo_full;
        bus.req1_ready = gnt && !fifo_full;
        accept         = g_valid && !fifo_full;
        frame_end      = accept && (g_last || bin_max);
        if (frame_end || abort) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      gnt           <= 1'b1;
      bin           <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      bus.mp_valid  <= 1'b0;
      bus.mp_re     <= '0;
      bus.mp_im     <= '0;
      bus.out_valid <= 1'b0;
      bus.out_mag   <= '0;
      bus.out_chan  <= 1'b0;
      bus.out_bin   <= '0;
      bus.out_last  <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.tag_err   <= 1'b0;
    end else begin
      state         <= state_nxt;
      gnt           <= gnt_nxt;
      bus.mp_valid  <= accept;
      if (accept) begin
        bus.mp_re <= g_re;
        bus.mp_im <= g_im;
      end
      bus.frame_err <= (frame_end && (g_last != bin_max)) || abort;
      if (frame_end || abort) bin <= '0;
      else if (accept)        bin <= bin + 1'b1;

      if (accept) wr_ptr <= (wr_ptr == PW'(TAG_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)    rd_ptr <= (rd_ptr == PW'(TAG_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (accept && !pop)      count <= count + 1'b1;
      else if (pop && !accept) count <= count - 1'b1;

      bus.out_valid <= pop;
      if (pop) begin
        bus.out_mag <= bus.mp_mag_sq;
        {bus.out_chan, bus.out_bin, bus.out_last} <= tag_mem[rd_ptr];
      end
      if (bus.mp_mag_valid && (count == '0)) bus.tag_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) tag_mem[wr_ptr] <= {gnt, bin, frame_end};
  end

`ifdef FFT_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] stall_cnt;

  assign abort = (state == BUSY) && !g_valid && (stall_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                stall_cnt <= '0;
    else if ((state != BUSY) || accept || abort) stall_cnt <= '0;
    else if (!g_valid)                           stall_cnt <= stall_cnt + 1'b1;
  end
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT != 0);
  assign abort          = 1'b0;
`endif
endmodule

// File: tb/tb_fft_mag_arbiter.sv
// Scoreboard bench for fft_mag_arbiter with NBINS=8 and a 3-cycle magnitude-unit model.
// The stall-abort scenario runs only when FFT_ARB_TIMEOUT_EN is defined.
module tb_fft_mag_arbiter;
  localparam int W     = 16;
  localparam int NBINS = 8;
  localparam int LB    = 3;

  typedef struct packed {
    logic [63:0]   mag;
    logic          ch;
    logic [LB-1:0] bin;
    logic          last;
  } exp_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  logic inj     = 1'b0;
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   ferr_cnt = 0;
  int   exp_bin  = 0;

  exp_t exp_q[$];
  int   acc_ch_q[$];
  int   acc_cyc_q[$];
  int   out_cyc_q[$];

  logic        v1, v2, v3;
  logic [63:0] d1, d2, d3;

  fft_mag_arbiter_if #(.W(W), .NBINS(NBINS)) bus ();

  fft_mag_arbiter #(.W(W), .NBINS(NBINS), .TAG_DEPTH(4), .TIMEOUT(16)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] sq(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return 64'(sa * sa + sb * sb);
  endfunction

  // Magnitude unit: 3-cycle pipeline, reset together with the arbiter.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
      d1 <= '0;   d2 <= '0;   d3 <= '0;
    end else begin
      v1 <= bus.mp_valid; d1 <= sq(bus.mp_re, bus.mp_im);
      v2 <= v1;           d2 <= d1;
      v3 <= v2;           d3 <= d2;
    end
  end
  assign bus.mp_mag_valid = v3 | inj;
  assign bus.mp_mag_sq    = inj ? 64'h0000_0000_0000_DEAD : d3;

  function automatic void note_accept(input logic ch, input logic [31:0] re,
                                      input logic [31:0] im, input logic last);
    exp_t e;
    logic end_b;
    end_b  = last || (exp_bin == NBINS - 1);
    e.mag  = sq(re, im);
    e.ch   = ch;
    e.bin  = LB'(exp_bin);
    e.last = end_b;
    exp_q.push_back(e);
    acc_ch_q.push_back(int'(ch));
    acc_cyc_q.push_back(cyc);
    exp_bin = end_b ? 0 : exp_bin + 1;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset_n) begin
      exp_q.delete();
      exp_bin = 0;
    end else begin
      if (bus.req0_valid && bus.req0_ready) note_accept(1'b0, bus.req0_re, bus.req0_im, bus.req0_last);
      if (bus.req1_valid && bus.req1_ready) note_accept(1'b1, bus.req1_re, bus.req1_im, bus.req1_last);
      checks++;
      if (bus.req0_ready && bus.req1_ready) begin
        errors++;
        $display("FAIL ready_exclusive: req0_ready=1 req1_ready=1, required at most one high");
      end
      if (bus.frame_err) ferr_cnt++;
      if (bus.out_valid) begin
        out_cyc_q.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected: out_valid=1 chan=%0d bin=%0d, required no output",
                   bus.out_chan, bus.out_bin);
        end else begin
          e = exp_q.pop_front();
          if ({bus.out_mag, bus.out_chan, bus.out_bin, bus.out_last} !== e) begin
            errors++;
            $display("FAIL out_data: got mag=%0d chan=%0d bin=%0d last=%0d, required mag=%0d chan=%0d bin=%0d last=%0d",
                     bus.out_mag, bus.out_chan, bus.out_bin, bus.out_last, e.mag, e.ch, e.bin, e.last);
          end
        end
      end
    end
  end

  function automatic logic [138:0] all_outs();
    return {bus.req0_ready, bus.req1_ready, bus.mp_valid, bus.mp_re, bus.mp_im,
            bus.out_valid, bus.out_mag, bus.out_chan, bus.out_bin, bus.out_last,
            bus.frame_err, bus.tag_err};
  endfunction

  task automatic clear_logs();
    acc_ch_q.delete();
    acc_cyc_q.delete();
    out_cyc_q.delete();
  endtask

  task automatic do_reset();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_last  = 1'b0; bus.req1_last  = 1'b0;
    inj = 1'b0;
    @(posedge clk); #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Sends nbeats beats on channel ch; last is raised on beat last_at (-1: never).
  task automatic run_frame(input int ch, input int nbeats, input int last_at, input bit ramp);
    logic [31:0] re, im;
    int r, waited;
    bit acc;
    for (int k = 0; k < nbeats; k++) begin
      if (ramp) begin
        re = 32'(k);
        im = '0;
      end else begin
        r  = $urandom_range(0, 4000); re = 32'(r - 2000);
        r  = $urandom_range(0, 4000); im = 32'(r - 2000);
      end
      if (ch == 0) begin
        bus.req0_valid = 1'b1; bus.req0_re = re; bus.req0_im = im; bus.req0_last = (k == last_at);
      end else begin
        bus.req1_valid = 1'b1; bus.req1_re = re; bus.req1_im = im; bus.req1_last = (k == last_at);
      end
      acc = 1'b0;
      waited = 0;
      while (!acc && waited <= 200) begin
        @(negedge clk);
        acc = (ch == 0) ? bus.req0_ready : bus.req1_ready;
        @(posedge clk); #1;
        waited++;
      end
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL accept_wait: ch%0d beat %0d not accepted in 200 cycles, required acceptance", ch, k);
        break;
      end
    end
    if (ch == 0) begin bus.req0_valid = 1'b0; bus.req0_last = 1'b0; end
    else         begin bus.req1_valid = 1'b0; bus.req1_last = 1'b0; end
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #2;
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required all zero", all_outs());
    end
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL reset_idle: got %h, required all zero after release", all_outs());
    end
  endtask

  task automatic test_single_frame();
    int f0, lat, span;
    do_reset();
    clear_logs();
    f0 = ferr_cnt;
    run_frame(0, 8, 7, 1'b1);
    repeat (8) @(posedge clk); #1;
    checks++;
    if (out_cyc_q.size() != 8) begin
      errors++;
      $display("FAIL single_count: got %0d outputs, required 8", out_cyc_q.size());
    end
    lat  = (out_cyc_q.size() > 0 && acc_cyc_q.size() > 0) ? out_cyc_q[0] - acc_cyc_q[0] : -1;
    span = (out_cyc_q.size() > 0) ? out_cyc_q[out_cyc_q.size()-1] - out_cyc_q[0] : -1;
    checks++;
    if (lat != 5) begin
      errors++;
      $display("FAIL single_latency: got %0d cycles, required 5", lat);
    end
    checks++;
    if (span != 7) begin
      errors++;
      $display("FAIL single_burst: got span %0d cycles, required 7", span);
    end
    checks++;
    if (ferr_cnt - f0 != 0) begin
      errors++;
      $display("FAIL single_frame_err: got %0d pulses, required 0", ferr_cnt - f0);
    end
  endtask

  task automatic test_back_to_back();
    int bad_ch, bad_gap;
    do_reset();
    clear_logs();
    fork
      begin run_frame(0, 8, 7, 1'b0); run_frame(0, 8, 7, 1'b0); end
      begin run_frame(1, 8, 7, 1'b0); run_frame(1, 8, 7, 1'b0); end
    join
    repeat (8) @(posedge clk); #1;
    checks++;
    if (acc_ch_q.size() != 32) begin
      errors++;
      $display("FAIL rr_count: got %0d accepts, required 32", acc_ch_q.size());
    end else begin
      bad_ch  = 0;
      bad_gap = 0;
      for (int i = 0; i < 32; i++) begin
        if (acc_ch_q[i] != (i / 8) % 2) bad_ch++;
        if (i < 31 && acc_cyc_q[i+1] - acc_cyc_q[i] != ((i % 8 == 7) ? 2 : 1)) bad_gap++;
      end
      checks++;
      if (bad_ch != 0) begin
        errors++;
        $display("FAIL rr_order: got %0d beats on wrong channel, required 0 (order ch0,ch1,ch0,ch1)", bad_ch);
      end
      checks++;
      if (bad_gap != 0) begin
        errors++;
        $display("FAIL rr_spacing: got %0d irregular gaps, required 0", bad_gap);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rr_drain: got %0d outputs missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_short_frame();
    int f0;
    do_reset();
    f0 = ferr_cnt;
    run_frame(0, 5, 4, 1'b0);
    repeat (2) @(posedge clk); #1;
    checks++;
    if (ferr_cnt - f0 != 1) begin
      errors++;
      $display("FAIL short_frame_err: got %0d pulses, required 1", ferr_cnt - f0);
    end
    run_frame(0, 8, 7, 1'b0);
    repeat (8) @(posedge clk); #1;
    checks++;
    if (ferr_cnt - f0 != 1) begin
      errors++;
      $display("FAIL short_next_frame_err: got %0d pulses, required 1", ferr_cnt - f0);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL short_drain: got %0d outputs missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_long_frame();
    int f0;
    do_reset();
    clear_logs();
    f0 = ferr_cnt;
    run_frame(1, 9, -1, 1'b0);
    repeat (8) @(posedge clk); #1;
    checks++;
    if (ferr_cnt - f0 != 1) begin
      errors++;
      $display("FAIL long_frame_err: got %0d pulses, required 1", ferr_cnt - f0);
    end
    checks++;
    if (out_cyc_q.size() != 9 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL long_count: got %0d outputs (%0d pending), required 9 (0 pending)",
               out_cyc_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    run_frame(0, 4, -1, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got %h, required all zero", all_outs());
    end
    @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    clear_logs();
    fork
      run_frame(0, 8, 7, 1'b0);
      run_frame(1, 8, 7, 1'b0);
    join
    repeat (8) @(posedge clk); #1;
    checks++;
    if (acc_ch_q.size() != 16 || acc_ch_q[0] != 0 || acc_ch_q[8] != 1) begin
      errors++;
      $display("FAIL midreset_priority: got %0d accepts first ch%0d, required 16 with ch0 first",
               acc_ch_q.size(), (acc_ch_q.size() > 0) ? acc_ch_q[0] : -1);
    end
    checks++;
    if (bus.tag_err !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_clean: got tag_err=%b pending=%0d, required 0 and 0",
               bus.tag_err, exp_q.size());
    end
  endtask

  task automatic test_tag_err();
    @(posedge clk); #1 inj = 1'b1;
    @(posedge clk); #1 inj = 1'b0;
    checks++;
    if (bus.tag_err !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL tag_err_set: got tag_err=%b out_valid=%b, required 1 and 0", bus.tag_err, bus.out_valid);
    end
    repeat (4) @(posedge clk); #1;
    checks++;
    if (bus.tag_err !== 1'b1) begin
      errors++;
      $display("FAIL tag_err_sticky: got %b, required 1", bus.tag_err);
    end
  endtask

`ifdef FFT_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int f0, gap;
    do_reset();
    clear_logs();
    f0 = ferr_cnt;
    run_frame(0, 3, -1, 1'b0);
    exp_bin = 0;
    run_frame(1, 8, 7, 1'b0);
    repeat (8) @(posedge clk); #1;
    checks++;
    if (ferr_cnt - f0 != 1) begin
      errors++;
      $display("FAIL timeout_frame_err: got %0d pulses, required 1", ferr_cnt - f0);
    end
    gap = (acc_cyc_q.size() == 11) ? acc_cyc_q[3] - acc_cyc_q[2] : -1;
    checks++;
    if (gap != 18 || acc_ch_q[3] != 1) begin
      errors++;
      $display("FAIL timeout_regrant: got gap %0d, required 18 with ch1 granted", gap);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL timeout_drain: got %0d outputs missing, required 0", exp_q.size());
    end
  endtask
`endif

  initial begin
    bus.req0_valid = 1'b0; bus.req0_re = '0; bus.req0_im = '0; bus.req0_last = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_re = '0; bus.req1_im = '0; bus.req1_last = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_short_frame();
    test_long_frame();
    test_reset_mid_frame();
    test_tag_err();
`ifdef FFT_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
